button_conditioner: RTL and testbench

//   Turns a raw, asynchronous push-button into clean control strobes for speedSet.

---
 rtl/button_conditioner_if.sv | 11 +
 rtl/button_conditioner.sv | 148 ++++++++++++++
 tb/tb_button_conditioner.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/button_conditioner_if.sv
// Button-side signal bundle for button_conditioner: raw button in,
// conditioned strobes and levels out.
interface button_conditioner_if;
  logic btn_in;
  logic pressed;
  logic btn_level;
  logic held;

  modport master (output btn_in, input pressed, input btn_level, input held);
  modport slave  (input btn_in, output pressed, output btn_level, output held);
endinterface

// File: rtl/button_conditioner.sv
// Synchronises and debounces a raw push-button, then emits one strobe per press
// plus optional auto-repeat strobes while the button stays held.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 50,
  parameter int REPEAT_CYCLES   = 20,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  button_conditioner_if.slave  bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_ONE    = DW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);
  localparam logic [RW-1:0] REP_ONE   = RW'(1);

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    HOLDING   = 2'd1,
    REPEATING = 2'd2
  } state_t;

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          rise_accept, fall_accept;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          held_q, held_d;
  logic          pressed_q, pressed_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= bus.btn_in;
      s2_q <= s1_q;
    end
  end

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    level_d     = level_q;
    db_cnt_d    = db_cnt_q;
    rise_accept = 1'b0;
    fall_accept = 1'b0;
    if (s2_q == level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      level_d     = s2_q;
      db_cnt_d    = '0;
      rise_accept = s2_q;
      fall_accept = ~s2_q;
    end else begin
      db_cnt_d = db_cnt_q + DB_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q  <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    held_d     = held_q;
    pressed_d  = 1'b0;
    // A release overrides any hold or repeat tick landing in the same cycle.
    if (fall_accept) begin
      state_d    = RELEASED;
      held_d     = 1'b0;
      hold_cnt_d = '0;
      rep_cnt_d  = '0;
    end else begin
      case (state_q)
        RELEASED: begin
          if (rise_accept) begin
            pressed_d  = 1'b1;
            hold_cnt_d = '0;
            state_d    = HOLDING;
          end
        end
        HOLDING: begin
          if (level_q) begin
            if (hold_cnt_q == HOLD_LAST) begin
              held_d    = 1'b1;
              rep_cnt_d = '0;
              pressed_d = REPEAT_EN;
              state_d   = REPEATING;
            end else begin
              hold_cnt_d = hold_cnt_q + HOLD_ONE;
            end
          end
        end
        REPEATING: begin
          if (rep_cnt_q == REP_LAST) begin
            rep_cnt_d = '0;
            pressed_d = REPEAT_EN;
          end else begin
            rep_cnt_d = rep_cnt_q + REP_ONE;
          end
        end
        default: begin
          state_d = RELEASED;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RELEASED;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      held_q     <= 1'b0;
      pressed_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      held_q     <= held_d;
      pressed_q  <= pressed_d;
    end
  end

  assign bus.pressed   = pressed_q;
  assign bus.btn_level = level_q;
  assign bus.held      = held_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: two instances (repeat on / off) share
// one raw button; expected pulse cycles are queued when stimulus is applied.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic reset;
  logic btnIn;

  button_conditioner_if busRep ();
  button_conditioner_if busNoRep ();

  assign busRep.btn_in   = btnIn;
  assign busNoRep.btn_in = btnIn;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(50), .REPEAT_CYCLES(20), .REPEAT_EN(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .bus(busRep)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(50), .REPEAT_CYCLES(20), .REPEAT_EN(1'b0)
  ) dutNoRep (
    .clk(clk), .reset(reset), .bus(busNoRep)
  );

  always #5 clk = ~clk;

  int cycleCount = 0;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  int checkCount = 0;
  int errorCount = 0;
  int expRep[$];
  int expNoRep[$];
  bit monitorOn = 1'b0;
  int heldHighCount;
  int levelHighCount;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed != expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Every pressed strobe is matched against the next queued cycle number.
  logic prevRep = 1'b0;
  logic prevNoRep = 1'b0;
  always @(negedge clk) begin
    if (monitorOn) begin
      if (busRep.pressed === 1'b1) begin
        checkOutput("repBackToBack", int'(prevRep), 0);
        if (expRep.size() == 0) checkOutput("repSpuriousPulse", cycleCount, -1);
        else checkOutput("repPulseCycle", cycleCount, expRep.pop_front());
      end
      if (busNoRep.pressed === 1'b1) begin
        if (expNoRep.size() == 0) checkOutput("noRepSpuriousPulse", cycleCount, -1);
        else checkOutput("noRepPulseCycle", cycleCount, expNoRep.pop_front());
      end
    end
    prevRep   <= busRep.pressed;
    prevNoRep <= busNoRep.pressed;
  end

  task automatic advanceTo(input int target);
    while (cycleCount < target) begin
      @(negedge clk);
      if (busRep.held === 1'b1) heldHighCount++;
      if (busRep.btn_level === 1'b1) levelHighCount++;
    end
  endtask

  task automatic applyStimulus(input logic value, input int cycles);
    btnIn = value;
    advanceTo(cycleCount + cycles);
  endtask

  task automatic checkQueuesDrained(input string tag);
    checkOutput({tag, "RepLeft"}, expRep.size(), 0);
    checkOutput({tag, "NoRepLeft"}, expNoRep.size(), 0);
    expRep.delete();
    expNoRep.delete();
  endtask

  initial begin
    int e0;
    int r;
    int val;
    int elapsed;
    int n;

    btnIn = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    monitorOn = 1'b1;
    checkOutput("resetPressed", int'(busRep.pressed), 0);
    checkOutput("resetLevel", int'(busRep.btn_level), 0);
    checkOutput("resetHeld", int'(busRep.held), 0);
    checkOutput("resetNoRepHeld", int'(busNoRep.held), 0);

    $display("[TB] idle with button released");
    heldHighCount  = 0;
    levelHighCount = 0;
    applyStimulus(1'b0, 200);
    checkOutput("idleHeldCycles", heldHighCount, 0);
    checkOutput("idleLevelCycles", levelHighCount, 0);

    $display("[TB] short press");
    heldHighCount = 0;
    e0 = cycleCount + 1;
    expRep.push_back(e0 + 5);
    expNoRep.push_back(e0 + 5);
    btnIn = 1'b1;
    advanceTo(e0 + 4);
    checkOutput("shortLevelBefore", int'(busRep.btn_level), 0);
    advanceTo(e0 + 5);
    checkOutput("shortLevelRise", int'(busRep.btn_level), 1);
    advanceTo(e0 + 9);
    btnIn = 1'b0;
    advanceTo(e0 + 14);
    checkOutput("shortLevelStill", int'(busRep.btn_level), 1);
    advanceTo(e0 + 15);
    checkOutput("shortLevelFall", int'(busRep.btn_level), 0);
    advanceTo(e0 + 30);
    checkOutput("shortHeldCycles", heldHighCount, 0);
    checkQueuesDrained("short");

    $display("[TB] bouncing contact");
    levelHighCount = 0;
    val = 1;
    elapsed = 0;
    forever begin
      n = int'($urandom_range(1, 3));
      applyStimulus(val[0], n);
      elapsed += n;
      if (elapsed >= 30 && val == 0) break;
      val = 1 - val;
    end
    checkOutput("bounceLevelCycles", levelHighCount, 0);
    e0 = cycleCount + 1;
    expRep.push_back(e0 + 5);
    expNoRep.push_back(e0 + 5);
    btnIn = 1'b1;
    advanceTo(e0 + 5);
    checkOutput("bounceSettledLevel", int'(busRep.btn_level), 1);
    advanceTo(e0 + 10);
    applyStimulus(1'b0, 20);
    checkQueuesDrained("bounce");

    $display("[TB] long hold with and without repeat");
    e0 = cycleCount + 1;
    expRep.push_back(e0 + 5);
    expRep.push_back(e0 + 55);
    expRep.push_back(e0 + 75);
    expRep.push_back(e0 + 95);
    expNoRep.push_back(e0 + 5);
    btnIn = 1'b1;
    advanceTo(e0 + 54);
    checkOutput("holdHeldEarly", int'(busRep.held), 0);
    checkOutput("holdNoRepHeldEarly", int'(busNoRep.held), 0);
    advanceTo(e0 + 55);
    checkOutput("holdHeldRise", int'(busRep.held), 1);
    checkOutput("holdNoRepHeldRise", int'(busNoRep.held), 1);
    advanceTo(e0 + 99);
    btnIn = 1'b0;
    advanceTo(e0 + 104);
    checkOutput("holdHeldBeforeFall", int'(busRep.held), 1);
    advanceTo(e0 + 105);
    checkOutput("holdHeldFall", int'(busRep.held), 0);
    checkOutput("holdNoRepHeldFall", int'(busNoRep.held), 0);
    checkOutput("holdLevelFall", int'(busRep.btn_level), 0);
    advanceTo(e0 + 130);
    checkQueuesDrained("hold");

    $display("[TB] reset while repeating");
    e0 = cycleCount + 1;
    expRep.push_back(e0 + 5);
    expRep.push_back(e0 + 55);
    expNoRep.push_back(e0 + 5);
    btnIn = 1'b1;
    advanceTo(e0 + 60);
    r = cycleCount;
    reset = 1'b1;
    advanceTo(r + 1);
    checkOutput("midResetPressed", int'(busRep.pressed), 0);
    checkOutput("midResetLevel", int'(busRep.btn_level), 0);
    checkOutput("midResetHeld", int'(busRep.held), 0);
    checkOutput("midResetNoRepHeld", int'(busNoRep.held), 0);
    advanceTo(r + 2);
    reset = 1'b0;
    expRep.push_back(r + 8);
    expNoRep.push_back(r + 8);
    advanceTo(r + 7);
    checkOutput("postResetLevelEarly", int'(busRep.btn_level), 0);
    advanceTo(r + 8);
    checkOutput("postResetLevelRise", int'(busRep.btn_level), 1);
    applyStimulus(1'b0, 20);
    checkQueuesDrained("reset");

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=%0d expected=finished", cycleCount);
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule
